// File: rtl/edp_diag_reader_pkg.sv
// Shared definitions for the EDP diagnostic reader: register-select codes,
// the diagnostic function prefix and the FSM state encoding.
package edp_diag_reader_pkg;

    // Register selects as presented on reqSel / rdSel
    localparam logic [2:0] SEL_AR  = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_MQ  = 3'd2;
    localparam logic [2:0] SEL_FM  = 3'd3;
    localparam logic [2:0] SEL_BRX = 3'd4;
    localparam logic [2:0] SEL_ARX = 3'd5;
    localparam logic [2:0] SEL_ADX = 3'd6;
    localparam logic [2:0] SEL_AD  = 3'd7;

    // Upper bits of every diagnostic read function code
    localparam logic [3:0] DIAG_FUNC_PREFIX = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Function code that asks the data path to drive the selected register
    function automatic logic [0:8] diag_func(input logic [2:0] sel);
        return {DIAG_FUNC_PREFIX, sel, 2'b00};
    endfunction

endpackage

// File: rtl/edp_diag_reader_if.sv
// Request/data-path bundle for the diagnostic reader.
// Handshake: req/dumpAll are sampled only while the reader is idle (busy=0);
// a read is accepted on the edge that samples them high, and each select
// later yields exactly one single-cycle rdValid or rdErr pulse.
// The data path holds EDPdrivingEBUS high while EBUS carries valid data.
interface edp_diag_reader_if;
    import edp_diag_reader_pkg::*;

    logic        req;
    logic [0:2]  reqSel;
    logic        dumpAll;
    logic [0:35] EBUS;
    logic        EDPdrivingEBUS;
    logic [0:8]  diagFunc;
    logic        diagReadFunc12X;
    logic        busy;
    logic [0:35] rdData;
    logic [0:2]  rdSel;
    logic        rdValid;
    logic        rdLast;
    logic        rdErr;
    state_t      state;

    modport master (
        output req, reqSel, dumpAll, EBUS, EDPdrivingEBUS,
        input  diagFunc, diagReadFunc12X, busy, rdData, rdSel,
               rdValid, rdLast, rdErr, state
    );

    modport slave (
        input  req, reqSel, dumpAll, EBUS, EDPdrivingEBUS,
        output diagFunc, diagReadFunc12X, busy, rdData, rdSel,
               rdValid, rdLast, rdErr, state
    );
endinterface

// File: rtl/edp_diag_reader.sv
// Reads single data-path registers (or all eight in sequence) through the
// diagnostic EBUS: drive the function code, wait for the data path to
// acknowledge, let EBUS settle, capture, then release the bus for a cycle.
module edp_diag_reader
    import edp_diag_reader_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic              clk,
    input logic              reset,
    edp_diag_reader_if.slave bus
);

    localparam logic [3:0] SETTLE_LOAD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cursor_q;
    logic        dump_q;
    logic [3:0]  settle_q;
    logic [7:0]  wait_q;
    logic [0:35] rd_data_q;
    logic [2:0]  rd_sel_q;
    logic        rd_valid_q, rd_last_q, rd_err_q;
    logic        capture, timeout, strobe;

    // Next-state logic plus the capture/timeout events of the current cycle
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dumpAll || bus.req) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (bus.EDPdrivingEBUS) begin
                    state_d = ST_SETTLE;
                end else if (wait_q == TIMEOUT_LAST) begin
                    state_d = ST_RELEASE;
                    timeout = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!bus.EDPdrivingEBUS) state_d = ST_DRIVE;
                else if (settle_q == 4'd0) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                state_d = ST_RELEASE;
                capture = 1'b1;
            end
            ST_RELEASE: begin
                if (dump_q && cursor_q != SEL_AD) state_d = ST_DRIVE;
                else state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, cursor/counters and the registered result pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cursor_q   <= 3'd0;
            dump_q     <= 1'b0;
            settle_q   <= 4'd0;
            wait_q     <= 8'd0;
            rd_data_q  <= '0;
            rd_sel_q   <= 3'd0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= capture;
            rd_err_q   <= timeout;
            rd_last_q  <= (capture || timeout) && dump_q && (cursor_q == SEL_AD);
            if (capture) begin
                rd_data_q <= bus.EBUS;
                rd_sel_q  <= cursor_q;
            end else if (timeout) begin
                rd_data_q <= '0;
                rd_sel_q  <= cursor_q;
            end
            case (state_q)
                ST_IDLE: begin
                    // dumpAll has priority over a simultaneous single request
                    if (bus.dumpAll) begin
                        cursor_q <= SEL_AR;
                        dump_q   <= 1'b1;
                        wait_q   <= 8'd0;
                    end else if (bus.req) begin
                        cursor_q <= bus.reqSel;
                        dump_q   <= 1'b0;
                        wait_q   <= 8'd0;
                    end
                end
                ST_DRIVE: begin
                    // Wait time accumulates across ack glitches for one select
                    if (bus.EDPdrivingEBUS) settle_q <= SETTLE_LOAD;
                    else wait_q <= wait_q + 8'd1;
                end
                ST_SETTLE: begin
                    if (!bus.EDPdrivingEBUS) settle_q <= SETTLE_LOAD;
                    else if (settle_q != 4'd0) settle_q <= settle_q - 4'd1;
                end
                ST_RELEASE: begin
                    if (dump_q && cursor_q != SEL_AD) begin
                        cursor_q <= cursor_q + 3'd1;
                        wait_q   <= 8'd0;
                    end else begin
                        dump_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign strobe              = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                                 (state_q == ST_SAMPLE);
    assign bus.diagReadFunc12X = strobe;
    assign bus.diagFunc        = strobe ? diag_func(cursor_q) : 9'd0;
    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.rdData          = rd_data_q;
    assign bus.rdSel           = rd_sel_q;
    assign bus.rdValid         = rd_valid_q;
    assign bus.rdLast          = rd_last_q;
    assign bus.rdErr           = rd_err_q;
    assign bus.state           = state_q;

endmodule

// File: tb/tb_edp_diag_reader.sv
// Directed bench for edp_diag_reader with a small data-path model that can
// acknowledge immediately, never, or a few cycles after the strobe rises.
module tb_edp_diag_reader;
    import edp_diag_reader_pkg::*;

    localparam int ACK_ALWAYS  = 0;
    localparam int ACK_NEVER   = 1;
    localparam int ACK_DELAYED = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    edp_diag_reader_if bus();

    edp_diag_reader #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock
    always #5 clk = ~clk;

    // Data path model
    int          ack_mode = ACK_ALWAYS;
    logic        ack_low  = 1'b0;
    logic        use_fixed = 1'b1;
    logic [0:35] fixed_word = '0;
    int          strobe_cnt = 0;
    logic [2:0]  model_sel;

    always @(posedge clk) begin
        if (bus.diagReadFunc12X) strobe_cnt <= strobe_cnt + 1;
        else strobe_cnt <= 0;
    end

    always_comb begin
        model_sel = bus.diagFunc[4:6];
        bus.EDPdrivingEBUS = !ack_low && (ack_mode == ACK_ALWAYS ||
                             (ack_mode == ACK_DELAYED && strobe_cnt >= 3));
        if (!bus.EDPdrivingEBUS) bus.EBUS = '0;
        else if (use_fixed) bus.EBUS = fixed_word;
        else bus.EBUS = 36'(model_sel) * 36'o111111111111;
    end

    // Pulse monitor
    int          cyc = 0;
    int          valid_cnt = 0, err_cnt = 0, last_cnt = 0;
    logic [2:0]  sel_q[$];
    logic [35:0] exp_q[$];
    int          cyc_q[$];
    logic        last_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.rdValid) begin
            valid_cnt++;
            sel_q.push_back(bus.rdSel);
            exp_q.push_back(bus.rdData);
            cyc_q.push_back(cyc);
            last_q.push_back(bus.rdLast);
        end
        if (bus.rdErr) err_cnt++;
        if (bus.rdLast) last_cnt++;
    end

    // Driver / check tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cnt = 0; err_cnt = 0; last_cnt = 0;
        sel_q.delete(); exp_q.delete(); cyc_q.delete(); last_q.delete();
    endtask

    // Ticks until rdValid or rdErr; lat = ticks taken, -1 if never seen
    task automatic wait_result(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.rdValid || bus.rdErr) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (bus.busy && n < max) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c0;
        bus.req = 1'b0; bus.reqSel = 3'd0; bus.dumpAll = 1'b0;
        reset = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_strobe", 64'(bus.diagReadFunc12X), 64'd0);
        check("rst_func", 64'(bus.diagFunc), 64'd0);
        check("rst_data", 64'(bus.rdData), 64'd0);
        check("rst_flags", {61'd0, bus.rdValid, bus.rdLast, bus.rdErr}, 64'd0);
        reset = 1'b0;
        tick();
        check("rst_state", 64'(bus.state), 64'(ST_IDLE));

        // Single read of MQ with the data path already acknowledging
        ack_mode = ACK_ALWAYS; use_fixed = 1'b1; fixed_word = 36'o123456701234;
        clear_mon();
        bus.req = 1'b1; bus.reqSel = 3'd2;
        tick();
        bus.req = 1'b0;
        check("single_strobe", 64'(bus.diagReadFunc12X), 64'd1);
        check("single_func", 64'(bus.diagFunc), 64'(9'b0101_010_00));
        check("single_busy", 64'(bus.busy), 64'd1);
        wait_result(10, lat);
        check("single_lat", 64'(lat + 1), 64'd5);
        check("single_valid", 64'(bus.rdValid), 64'd1);
        check("single_data", 64'(bus.rdData), 64'(36'o123456701234));
        check("single_sel", 64'(bus.rdSel), 64'd2);
        check("single_rel_strobe", 64'(bus.diagReadFunc12X), 64'd0);
        check("single_last", 64'(bus.rdLast), 64'd0);
        tick();
        check("single_idle", 64'(bus.busy), 64'd0);
        check("single_pulse_cnt", 64'(valid_cnt), 64'd1);

        // Timeout on ARX: no acknowledge at all
        ack_mode = ACK_NEVER;
        clear_mon();
        bus.req = 1'b1; bus.reqSel = 3'd5;
        tick();
        bus.req = 1'b0;
        wait_result(30, lat);
        check("to_lat", 64'(lat + 1), 64'd16);
        check("to_err", 64'(bus.rdErr), 64'd1);
        check("to_valid", 64'(bus.rdValid), 64'd0);
        check("to_data", 64'(bus.rdData), 64'd0);
        check("to_sel", 64'(bus.rdSel), 64'd5);
        check("to_strobe", 64'(bus.diagReadFunc12X), 64'd0);
        tick();
        check("to_idle", 64'(bus.state), 64'(ST_IDLE));

        // Ack glitch during SETTLE on AD
        ack_mode = ACK_ALWAYS; fixed_word = 36'o777000111222;
        clear_mon();
        bus.req = 1'b1; bus.reqSel = 3'd7;
        tick();
        bus.req = 1'b0;
        tick();
        check("gl_settle", 64'(bus.state), 64'(ST_SETTLE));
        ack_low = 1'b1;
        tick();
        ack_low = 1'b0;
        check("gl_back_drive", 64'(bus.state), 64'(ST_DRIVE));
        wait_result(10, lat);
        check("gl_lat", 64'(lat), 64'd4);
        check("gl_data", 64'(bus.rdData), 64'(36'o777000111222));
        check("gl_sel", 64'(bus.rdSel), 64'd7);
        tick();
        check("gl_pulse_cnt", 64'(valid_cnt), 64'd1);

        // Dump with delayed acknowledge; req raised together with dumpAll
        // and again mid-dump, neither may add a read
        ack_mode = ACK_DELAYED; use_fixed = 1'b0;
        clear_mon();
        bus.dumpAll = 1'b1; bus.req = 1'b1; bus.reqSel = 3'd5;
        c0 = cyc;
        tick();
        bus.dumpAll = 1'b0; bus.req = 1'b0;
        repeat (10) tick();
        bus.req = 1'b1; bus.reqSel = 3'd1;
        tick();
        bus.req = 1'b0;
        wait_idle("dump_done", 100);
        repeat (10) tick();
        check("dump_pulse_cnt", 64'(valid_cnt), 64'd8);
        check("dump_err_cnt", 64'(err_cnt), 64'd0);
        check("dump_last_cnt", 64'(last_cnt), 64'd1);
        if (cyc_q.size() > 0) check("dump_first_lat", 64'(cyc_q[0] - c0), 64'd8);
        for (int i = 0; i < 8 && i < sel_q.size(); i++) begin
            check($sformatf("dump_sel%0d", i), 64'(sel_q[i]), 64'(i));
            check($sformatf("dump_data%0d", i), 64'(exp_q[i]), 64'(36'o111111111111 * i));
            check($sformatf("dump_last%0d", i), 64'(last_q[i]), 64'(i == 7));
            if (i > 0) check($sformatf("dump_gap%0d", i), 64'(cyc_q[i] - cyc_q[i-1]), 64'd8);
        end

        // Reset in the middle of a dump while select 3 is being driven
        ack_mode = ACK_ALWAYS;
        clear_mon();
        bus.dumpAll = 1'b1;
        tick();
        bus.dumpAll = 1'b0;
        lat = 0;
        while (!(bus.diagReadFunc12X && bus.diagFunc[4:6] == 3'd3) && lat < 60) begin
            tick();
            lat++;
        end
        check("mid_reached_sel3", 64'(bus.diagFunc), 64'(9'b0101_011_00));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_strobe", 64'(bus.diagReadFunc12X), 64'd0);
        check("mid_busy", 64'(bus.busy), 64'd0);
        check("mid_func", 64'(bus.diagFunc), 64'd0);
        check("mid_data", 64'(bus.rdData), 64'd0);
        check("mid_sel", 64'(bus.rdSel), 64'd0);
        check("mid_before_cnt", 64'(valid_cnt), 64'd3);
        repeat (20) tick();
        check("mid_no_more", 64'(valid_cnt), 64'd3);

        // Single read of AR after the interrupted dump
        use_fixed = 1'b1; fixed_word = 36'o555555555555;
        bus.req = 1'b1; bus.reqSel = 3'd0;
        tick();
        bus.req = 1'b0;
        wait_result(10, lat);
        check("post_lat", 64'(lat + 1), 64'd5);
        check("post_data", 64'(bus.rdData), 64'(36'o555555555555));
        check("post_sel", 64'(bus.rdSel), 64'd0);
        check("post_last", 64'(bus.rdLast), 64'd0);
        tick();
        check("post_idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
